// File: rtl/backlight_temporal_filter.sv
// -----------------------------------------------------------------------------
// backlight_temporal_filter
//
// Per-zone temporal IIR smoothing of MiniLED backlight levels, followed by an
// ambient-light scale and a minimum-level floor.
//
// Each zone keeps a 12-bit 8.4 fixed-point state word in a single-clock RAM.
// A sample passes through three register stages:
//   S1 : register the sample, issue the registered RAM read
//   S2 : compute new = prev + ((in<<4) - prev) >>> SHIFT_K   (clamped 0..4080)
//   S3 : write the state back, scale by the frame's ambient level, output
// so out_valid follows in_valid by exactly three cycles.
//
// While first_frame is set (from reset until the first frame_done) states are
// loaded directly from the input, so the RAM never needs clearing.
//
// Ports
//   i_pix_clk   : pixel clock, the only clock
//   rst         : synchronous active-high reset
//   in_valid    : zone sample strobe
//   in_idx      : zone index (samples with in_idx >= N_ZONES are dropped)
//   in_data     : raw zone brightness
//   frame_done  : single-cycle end-of-frame pulse
//   I_bright    : ambient light level, latched on frame_done
//   out_valid   : result strobe, three cycles after in_valid
//   out_idx     : zone index of out_data
//   out_data    : filtered, ambient-scaled zone level
//   frame_ready : single-cycle pulse once the ending frame has drained
// -----------------------------------------------------------------------------
module backlight_temporal_filter #(
    parameter int N_ZONES   = 360,
    parameter int SHIFT_K   = 2,
    parameter int MIN_LEVEL = 4
) (
    input  logic       i_pix_clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [8:0] in_idx,
    input  logic [7:0] in_data,
    input  logic       frame_done,
    input  logic [7:0] I_bright,
    output logic       out_valid,
    output logic [8:0] out_idx,
    output logic [7:0] out_data,
    output logic       frame_ready
);

    localparam logic [9:0]  ZONE_LIMIT = 10'(N_ZONES);
    localparam logic [7:0]  MIN_LVL    = 8'(MIN_LEVEL);
    localparam logic [12:0] STATE_MAX  = 13'd4080;

    // -------------------------------------------------------------------------
    // Storage and frame-level control
    // -------------------------------------------------------------------------
    logic [11:0] state_mem [0:N_ZONES-1];
    logic [11:0] ram_rd_reg;

    logic        first_frame_reg;
    logic [7:0]  bright_q_reg;

    // S1
    logic        s1_valid_reg;
    logic [8:0]  s1_idx_reg;
    logic [7:0]  s1_data_reg;
    logic        s1_first_reg;
    logic [8:0]  s1_scale_reg;
    logic        s1_fwd_hit_reg;
    logic [11:0] s1_fwd_data_reg;

    // S2
    logic        s2_valid_reg;
    logic [8:0]  s2_idx_reg;
    logic [11:0] s2_state_reg;
    logic [8:0]  s2_scale_reg;

    // S3 / outputs
    logic        out_valid_reg;
    logic [8:0]  out_idx_reg;
    logic [7:0]  out_data_reg;

    // frame_ready tracking
    logic        pending_reg;
    logic        wait_done_reg;
    logic        frame_ready_reg;

    logic        in_accept;
    assign in_accept = in_valid && ({1'b0, in_idx} < ZONE_LIMIT);

    // State RAM: registered read, write-back from S3. The write is suppressed
    // during reset so a sample caught mid-flight leaves no trace.
    always_ff @(posedge i_pix_clk) begin
        if (s2_valid_reg && !rst) begin
            state_mem[s2_idx_reg] <= s2_state_reg;
        end
        if (in_accept) begin
            ram_rd_reg <= state_mem[in_idx];
        end
    end

    // Ambient level and first-frame flag change only at frame boundaries.
    always_ff @(posedge i_pix_clk) begin
        if (rst) begin
            first_frame_reg <= 1'b1;
            bright_q_reg    <= 8'hFF;
        end else if (frame_done) begin
            first_frame_reg <= 1'b0;
            bright_q_reg    <= I_bright;
        end
    end

    // -------------------------------------------------------------------------
    // S1: capture the sample together with the frame context it belongs to.
    // first_frame and the scale are sampled here, so a sample arriving with
    // frame_done is still treated as part of the ending frame.
    // The RAM read issued this edge cannot see the write S3 performs on the
    // same edge, so that value is captured as a second forwarding source.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_pix_clk) begin
        if (rst) begin
            s1_valid_reg    <= 1'b0;
            s1_idx_reg      <= '0;
            s1_data_reg     <= '0;
            s1_first_reg    <= 1'b1;
            s1_scale_reg    <= '0;
            s1_fwd_hit_reg  <= 1'b0;
            s1_fwd_data_reg <= '0;
        end else begin
            s1_valid_reg    <= in_accept;
            s1_idx_reg      <= in_idx;
            s1_data_reg     <= in_data;
            s1_first_reg    <= first_frame_reg;
            s1_scale_reg    <= {1'b0, bright_q_reg} + 9'd1;
            s1_fwd_hit_reg  <= s2_valid_reg && (s2_idx_reg == in_idx);
            s1_fwd_data_reg <= s2_state_reg;
        end
    end

    // -------------------------------------------------------------------------
    // S2: IIR update. The newest in-flight result for the same zone wins:
    // the sample directly ahead (in S2 now), then the one written back while
    // this sample's RAM read was in progress, then the RAM itself.
    // -------------------------------------------------------------------------
    logic [11:0]        iir_prev;
    logic [11:0]        iir_target;
    logic signed [12:0] iir_diff;
    logic signed [12:0] iir_step;
    logic signed [13:0] iir_sum;
    logic [11:0]        iir_clamped;
    logic [11:0]        iir_new;

    always_comb begin
        iir_prev = ram_rd_reg;
        if (s2_valid_reg && (s2_idx_reg == s1_idx_reg)) begin
            iir_prev = s2_state_reg;
        end else if (s1_fwd_hit_reg) begin
            iir_prev = s1_fwd_data_reg;
        end

        iir_target = {s1_data_reg, 4'b0000};
        iir_diff   = $signed({1'b0, iir_target}) - $signed({1'b0, iir_prev});
        iir_step   = iir_diff >>> SHIFT_K;
        iir_sum    = $signed({2'b00, iir_prev}) + $signed({iir_step[12], iir_step});

        if (iir_sum[13]) begin
            iir_clamped = 12'd0;
        end else if (iir_sum[12:0] > STATE_MAX) begin
            iir_clamped = STATE_MAX[11:0];
        end else begin
            iir_clamped = iir_sum[11:0];
        end

        iir_new = s1_first_reg ? iir_target : iir_clamped;
    end

    always_ff @(posedge i_pix_clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_idx_reg   <= '0;
            s2_state_reg <= '0;
            s2_scale_reg <= '0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            s2_idx_reg   <= s1_idx_reg;
            s2_state_reg <= iir_new;
            s2_scale_reg <= s1_scale_reg;
        end
    end

    // -------------------------------------------------------------------------
    // S3: ambient scale (integer part * (bright+1)) >> 8, then lift small
    // non-zero results to MIN_LEVEL so a lit zone never falls below the
    // driver's usable minimum. Zero stays zero.
    // -------------------------------------------------------------------------
    logic [7:0] scaled;
    logic [7:0] floored;

    always_comb begin
        scaled  = 8'(({8'b0, s2_state_reg[11:4]} * {7'b0, s2_scale_reg}) >> 8);
        floored = scaled;
        if ((scaled != 8'd0) && (scaled < MIN_LVL)) begin
            floored = MIN_LVL;
        end
    end

    always_ff @(posedge i_pix_clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                out_idx_reg  <= s2_idx_reg;
                out_data_reg <= floored;
            end
        end
    end

    // -------------------------------------------------------------------------
    // frame_ready: armed by frame_done, fires once at least three cycles
    // later when no sample will occupy S1, S2 or the output stage. A further
    // frame_done while armed just restarts the wait, merging into one pulse.
    // -------------------------------------------------------------------------
    logic pipe_empty_next;
    logic fire;

    always_comb begin
        pipe_empty_next = !in_accept && !s1_valid_reg && !s2_valid_reg;
        fire            = pending_reg && wait_done_reg && pipe_empty_next && !frame_done;
    end

    always_ff @(posedge i_pix_clk) begin
        if (rst) begin
            pending_reg     <= 1'b0;
            wait_done_reg   <= 1'b0;
            frame_ready_reg <= 1'b0;
        end else begin
            frame_ready_reg <= fire;
            wait_done_reg   <= !frame_done;
            if (frame_done) begin
                pending_reg <= 1'b1;
            end else if (fire) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_idx     = out_idx_reg;
    assign out_data    = out_data_reg;
    assign frame_ready = frame_ready_reg;

endmodule

// File: doc/backlight_temporal_filter.md
BACKLIGHT_TEMPORAL_FILTER -- requirements
Module: backlight_temporal_filter

Interface
REQ-001 SHALL have parameter N_ZONES, default 360: number of backlight zones per frame.
REQ-002 SHALL have parameter SHIFT_K, default 2: IIR coefficient, alpha = 1/2^SHIFT_K; legal range 0..4.
REQ-003 SHALL have parameter MIN_LEVEL, default 4: output floor applied to any non-zero scaled result.
REQ-004 SHALL have port i_pix_clk, input, 1 bit: pixel clock; the only clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: zone sample strobe from the zone-averaging stage.
REQ-007 SHALL have port in_idx, input, 9 bits: zone index, 0..N_ZONES-1.
REQ-008 SHALL have port in_data, input, 8 bits: raw zone brightness.
REQ-009 SHALL have port frame_done, input, 1 bit: single-cycle end-of-frame pulse (flag_done).
REQ-010 SHALL have port I_bright, input, 8 bits: ambient light level from the sensor path.
REQ-011 SHALL have port out_valid, input-aligned output strobe, output, 1 bit.
REQ-012 SHALL have port out_idx, output, 9 bits: zone index of out_data.
REQ-013 SHALL have port out_data, output, 8 bits: filtered, ambient-scaled zone level to the MiniLED driver.
REQ-014 SHALL have port frame_ready, output, 1 bit: single-cycle pulse after the last result of a frame.

Function
REQ-015 SHALL hold one 12-bit state word (8.4 fixed point) per zone in an N_ZONES-deep single-clock RAM.
REQ-016 SHALL run a 3-stage pipeline: S1 registers the sample and reads state; S2 computes the IIR; S3 writes state back and scales; out_valid is asserted exactly 3 cycles after in_valid.
REQ-017 SHALL compute new = prev + (((in_data<<4) - prev) >>> SHIFT_K) using a 13-bit signed difference; result clamped to 0..4080.
REQ-018 SHALL load new = in_data<<4 directly (no filtering) for every zone while first_frame = 1.
REQ-019 SHALL clear first_frame on the first frame_done after reset.
REQ-020 SHALL forward the S2/S3 result instead of the RAM read when consecutive samples hit the same in_idx (no read-after-write hazard).
REQ-021 SHALL drop any sample with in_idx >= N_ZONES: no RAM write, no out_valid.
REQ-022 SHALL latch I_bright into bright_q only on frame_done, so the scale is constant within a frame; reset value of bright_q is 8'hFF.
REQ-023 SHALL compute out_data = (new[11:4] * (bright_q + 1)) >> 8.
REQ-024 SHALL raise out_data to MIN_LEVEL when that result is non-zero and below MIN_LEVEL; a result of 0 stays 0.
REQ-025 SHALL assert frame_ready once, when the pipeline holds no valid samples, at or after 3 cycles following frame_done.
REQ-026 SHALL merge a frame_done arriving while a frame_ready is pending into the pending pulse, producing one frame_ready.
REQ-027 SHALL, when in_valid and frame_done occur together, process the sample as part of the ending frame.

Reset
REQ-028 SHALL, while rst = 1, drive out_valid = 0, out_idx = 0, out_data = 0 and frame_ready = 0, flush all pipeline valids, set first_frame = 1 and set bright_q = 8'hFF.
REQ-029 SHALL leave RAM contents unspecified after reset; first_frame guarantees they are overwritten before use.
REQ-030 SHALL discard any in-flight sample on a mid-frame reset, producing no output for it.

Verification
REQ-031 SHALL pass: after reset, frame 0 zone 5 = 200, I_bright = 255 -> out_idx = 5, out_data = 200, 3 cycles after in_valid.
REQ-032 SHALL pass: SHIFT_K = 2, zone 5 previously 200 (post-frame_done), next input 0 -> out_data = 150, then 112, then 84 on the following frames.
REQ-033 SHALL pass: frame_done with I_bright = 127, next frame zone 0 = 255 steady -> out_data = 127; I_bright changes mid-frame -> no change until the next frame_done.
REQ-034 SHALL pass: back-to-back in_valid on idx 7 with values 0 then 255 in the filtering regime -> second output uses the forwarded state, matching a software model.
REQ-035 SHALL pass: in_idx = 360 -> no out_valid, state of all zones unchanged; filtered value 2 with scale 256 -> out_data = MIN_LEVEL = 4.
REQ-036 SHALL pass: rst asserted 1 cycle after in_valid -> no out_valid for that sample, first_frame = 1, and the next sample is loaded unfiltered.
